// File: rtl/vl_pkg.sv
// Shared types, legal SEW/LMUL encodings and helpers for the strip sequencer.
package vl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] SEW_8  = 8'd8;
    localparam logic [7:0] SEW_16 = 8'd16;
    localparam logic [7:0] SEW_32 = 8'd32;
    localparam logic [7:0] SEW_64 = 8'd64;

    localparam logic [4:0] LMUL_1 = 5'd1;
    localparam logic [4:0] LMUL_2 = 5'd2;
    localparam logic [4:0] LMUL_4 = 5'd4;
    localparam logic [4:0] LMUL_8 = 5'd8;

    localparam logic [2:0] SEW_8_LOG2  = 3'd3;
    localparam logic [2:0] SEW_16_LOG2 = 3'd4;
    localparam logic [2:0] SEW_32_LOG2 = 3'd5;
    localparam logic [2:0] SEW_64_LOG2 = 3'd6;

    localparam logic [1:0] LMUL_1_LOG2 = 2'd0;
    localparam logic [1:0] LMUL_2_LOG2 = 2'd1;
    localparam logic [1:0] LMUL_4_LOG2 = 2'd2;
    localparam logic [1:0] LMUL_8_LOG2 = 2'd3;

    // log2 of a legal SEW; illegal widths map to 0 and are rejected separately
    function automatic logic [2:0] sew_log2(input logic [7:0] sew);
        logic [2:0] r;
        case (sew)
            SEW_8:   r = SEW_8_LOG2;
            SEW_16:  r = SEW_16_LOG2;
            SEW_32:  r = SEW_32_LOG2;
            SEW_64:  r = SEW_64_LOG2;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    // log2 of a legal LMUL; illegal multipliers map to 0 and are rejected separately
    function automatic logic [1:0] lmul_log2(input logic [4:0] lmul);
        logic [1:0] r;
        case (lmul)
            LMUL_1:  r = LMUL_1_LOG2;
            LMUL_2:  r = LMUL_2_LOG2;
            LMUL_4:  r = LMUL_4_LOG2;
            LMUL_8:  r = LMUL_8_LOG2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // True only when both SEW and LMUL are one of the supported powers of two
    function automatic logic sew_lmul_legal(input logic [7:0] sew, input logic [4:0] lmul);
        logic sew_ok;
        logic lmul_ok;
        sew_ok  = (sew == SEW_8) || (sew == SEW_16) || (sew == SEW_32) || (sew == SEW_64);
        lmul_ok = (lmul == LMUL_1) || (lmul == LMUL_2) || (lmul == LMUL_4) || (lmul == LMUL_8);
        return sew_ok && lmul_ok;
    endfunction

endpackage

// File: rtl/vl_strip_calc.sv
// Combinational strip sizing: VLMAX from SEW/LMUL by shifting, then vl = min(rem, VLMAX).
module vl_strip_calc
    import vl_pkg::*;
#(
    parameter int VLEN  = 64,
    parameter int AVL_W = 9
) (
    input  logic [7:0]       sew,
    input  logic [4:0]       lmul,
    input  logic [AVL_W-1:0] rem,
    output logic [AVL_W-1:0] vlmax,
    output logic [AVL_W-1:0] vl,
    output logic             last,
    output logic             illegal
);

    localparam int VLEN_LOG2 = $clog2(VLEN);
    localparam logic [AVL_W-1:0] ONE = {{(AVL_W-1){1'b0}}, 1'b1};

    int sh_s;

    // VLMAX = 2^(log2 VLEN + log2 LMUL - log2 SEW); zero when the shape is unusable
    always_comb begin
        illegal = !sew_lmul_legal(sew, lmul);
        sh_s    = VLEN_LOG2 + int'(lmul_log2(lmul)) - int'(sew_log2(sew));
        if (illegal || (sh_s < 0) || (sh_s >= AVL_W)) begin
            vlmax = {AVL_W{1'b0}};
        end else begin
            vlmax = ONE << sh_s;
        end
        if (rem < vlmax) begin
            vl = rem;
        end else begin
            vl = vlmax;
        end
        last = (rem <= vlmax);
    end

endmodule

// File: rtl/vl_strip_sequencer.sv
// Strip-mining controller: splits one AVL request into VLMAX-sized strips
// handed to the vector lanes over valid/ready, then pulses done.
module vl_strip_sequencer
    import vl_pkg::*;
#(
    parameter int VLEN  = 64,
    parameter int AVL_W = 9,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_sew,
    input  logic [4:0]       req_lmul,
    input  logic [AVL_W-1:0] req_avl,
    output logic             strip_valid,
    input  logic             strip_ready,
    output logic [AVL_W-1:0] strip_vl,
    output logic [AVL_W-1:0] strip_base,
    output logic             strip_last,
    output logic             done_valid,
    output logic             done_err,
    output logic [CNT_W-1:0] done_strips,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [AVL_W-1:0] AVL_ZERO = {AVL_W{1'b0}};

    state_e           state_r, state_nx;
    logic [7:0]       sew_r, sew_nx;
    logic [4:0]       lmul_r, lmul_nx;
    logic [AVL_W-1:0] rem_r, rem_nx;
    logic [AVL_W-1:0] base_r, base_nx;
    logic [AVL_W-1:0] vl_r, vl_nx;
    logic [CNT_W-1:0] count_r, count_nx;
    logic             err_r, err_nx;
    logic             last_r, last_nx;

    logic             req_ready_r;
    logic             strip_valid_r;
    logic             done_valid_r;
    logic             done_err_r;
    logic [CNT_W-1:0] done_strips_r;
    logic             busy_r;

    logic [7:0]       calc_sew_s;
    logic [4:0]       calc_lmul_s;
    logic [AVL_W-1:0] calc_vlmax_s;
    logic [AVL_W-1:0] calc_vl_s;
    logic             calc_last_s;
    logic             calc_illegal_s;

    // While idle the calculator looks at the incoming request, otherwise at the latched shape
    always_comb begin
        if (state_r == ST_IDLE) begin
            calc_sew_s  = req_sew;
            calc_lmul_s = req_lmul;
        end else begin
            calc_sew_s  = sew_r;
            calc_lmul_s = lmul_r;
        end
    end

    vl_strip_calc #(
        .VLEN  (VLEN),
        .AVL_W (AVL_W)
    ) u_calc (
        .sew     (calc_sew_s),
        .lmul    (calc_lmul_s),
        .rem     (rem_r),
        .vlmax   (calc_vlmax_s),
        .vl      (calc_vl_s),
        .last    (calc_last_s),
        .illegal (calc_illegal_s)
    );

    // Next-state and datapath update; flush overrides everything and clears the counters
    always_comb begin
        state_nx = state_r;
        sew_nx   = sew_r;
        lmul_nx  = lmul_r;
        rem_nx   = rem_r;
        base_nx  = base_r;
        vl_nx    = vl_r;
        count_nx = count_r;
        err_nx   = err_r;
        last_nx  = last_r;
        if (flush) begin
            state_nx = ST_IDLE;
            sew_nx   = 8'd0;
            lmul_nx  = 5'd0;
            rem_nx   = AVL_ZERO;
            base_nx  = AVL_ZERO;
            vl_nx    = AVL_ZERO;
            count_nx = {CNT_W{1'b0}};
            err_nx   = 1'b0;
            last_nx  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        sew_nx   = req_sew;
                        lmul_nx  = req_lmul;
                        rem_nx   = req_avl;
                        base_nx  = AVL_ZERO;
                        count_nx = {CNT_W{1'b0}};
                        err_nx   = calc_illegal_s;
                        // A zero VLMAX could never make progress, so it finishes like an error
                        if (calc_illegal_s || (calc_vlmax_s == AVL_ZERO) || (req_avl == AVL_ZERO)) begin
                            state_nx = ST_DONE;
                        end else begin
                            state_nx = ST_CALC;
                        end
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    vl_nx    = calc_vl_s;
                    last_nx  = calc_last_s;
                    state_nx = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (strip_ready) begin
                        rem_nx  = rem_r - vl_r;
                        base_nx = base_r + vl_r;
                        if (count_r == CNT_MAX) begin
                            count_nx = count_r;
                        end else begin
                            count_nx = count_r + CNT_ONE;
                        end
                        if (last_r) begin
                            state_nx = ST_DONE;
                        end else begin
                            state_nx = ST_CALC;
                        end
                    end else begin
                        state_nx = ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sew_r   <= 8'd0;
            lmul_r  <= 5'd0;
            rem_r   <= AVL_ZERO;
            base_r  <= AVL_ZERO;
            vl_r    <= AVL_ZERO;
            count_r <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            sew_r   <= sew_nx;
            lmul_r  <= lmul_nx;
            rem_r   <= rem_nx;
            base_r  <= base_nx;
            vl_r    <= vl_nx;
            count_r <= count_nx;
            err_r   <= err_nx;
            last_r  <= last_nx;
        end
    end

    // Status outputs registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r   <= 1'b1;
            strip_valid_r <= 1'b0;
            done_valid_r  <= 1'b0;
            done_err_r    <= 1'b0;
            done_strips_r <= {CNT_W{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            req_ready_r   <= (state_nx == ST_IDLE);
            strip_valid_r <= (state_nx == ST_ISSUE);
            done_valid_r  <= (state_nx == ST_DONE);
            done_err_r    <= (state_nx == ST_DONE) && err_nx;
            done_strips_r <= (state_nx == ST_DONE) ? count_nx : {CNT_W{1'b0}};
            busy_r        <= (state_nx != ST_IDLE);
        end
    end

    assign req_ready   = req_ready_r;
    assign strip_valid = strip_valid_r;
    assign strip_vl    = vl_r;
    assign strip_base  = base_r;
    assign strip_last  = last_r;
    assign done_valid  = done_valid_r;
    assign done_err    = done_err_r;
    assign done_strips = done_strips_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_vl_strip_sequencer.sv
// Scoreboard bench for vl_strip_sequencer: stimulus pushes expected strips/done
// records, a negedge monitor pops and compares whenever the DUT presents them.
module tb_vl_strip_sequencer;

    localparam int AVL_W = 9;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [7:0]       req_sew = 8'd0;
    logic [4:0]       req_lmul = 5'd0;
    logic [AVL_W-1:0] req_avl = 9'd0;
    logic             strip_valid;
    logic             strip_ready = 1'b0;
    logic [AVL_W-1:0] strip_vl;
    logic [AVL_W-1:0] strip_base;
    logic             strip_last;
    logic             done_valid;
    logic             done_err;
    logic [CNT_W-1:0] done_strips;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [18:0] exp_strip_q[$];   // {vl, base, last}
    logic [9:0]  exp_done_q[$];    // {err, strips}

    vl_strip_sequencer #(.VLEN(64), .AVL_W(AVL_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sew     (req_sew),
        .req_lmul    (req_lmul),
        .req_avl     (req_avl),
        .strip_valid (strip_valid),
        .strip_ready (strip_ready),
        .strip_vl    (strip_vl),
        .strip_base  (strip_base),
        .strip_last  (strip_last),
        .done_valid  (done_valid),
        .done_err    (done_err),
        .done_strips (done_strips),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_strip(input logic [8:0] vl, input logic [8:0] base, input logic last);
        exp_strip_q.push_back({vl, base, last});
    endtask

    task automatic push_done(input logic err, input logic [8:0] strips);
        exp_done_q.push_back({err, strips});
    endtask

    // Monitor: compare presented strips and done pulses against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (strip_valid) begin
                if (exp_strip_q.size() == 0) begin
                    chk("strip_unexpected", 32'(strip_valid), 32'd0);
                end else if (strip_ready) begin
                    chk("strip", 32'({strip_vl, strip_base, strip_last}), 32'(exp_strip_q.pop_front()));
                end else begin
                    chk("strip_hold", 32'({strip_vl, strip_base, strip_last}), 32'(exp_strip_q[0]));
                end
            end
            if (done_valid) begin
                if (exp_done_q.size() == 0) begin
                    chk("done_unexpected", 32'(done_valid), 32'd0);
                end else begin
                    chk("done", 32'({done_err, done_strips}), 32'(exp_done_q.pop_front()));
                end
            end
        end
    end

    // Issue one request and drive strip_ready (always high, or stalled 'stall' cycles per strip)
    task automatic run_req(input logic [7:0] sew, input logic [4:0] lmul, input logic [8:0] avl,
                           input int exp_lat, input int stall, input string tag);
        int lat;
        int sc;
        int guard;
        bit seen_done;
        @(posedge clk); #1;
        chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        req_sew = sew; req_lmul = lmul; req_avl = avl; req_valid = 1'b1;
        strip_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!strip_valid && !done_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        sc = 0; seen_done = 1'b0; guard = 0;
        while (!seen_done && guard < 2000) begin
            if (done_valid) seen_done = 1'b1;
            chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
            if (!seen_done) begin
                if (stall > 0) begin
                    if (strip_valid && sc >= stall) begin
                        strip_ready = 1'b1;
                        sc = 0;
                    end else if (strip_valid) begin
                        strip_ready = 1'b0;
                        sc++;
                    end else begin
                        strip_ready = 1'b0;
                    end
                end
                @(posedge clk); #1;
                guard++;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_back_idle"}, 32'({req_ready, busy}), 32'd2);
        strip_ready = 1'b0;
    endtask

    initial begin
        int g;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_outputs", 32'({strip_valid, strip_vl, strip_base, strip_last, done_valid, done_err, busy}), 32'd0);
        chk("rst_done_strips", 32'(done_strips), 32'd0);
        rst_n = 1'b1;

        // 1: SEW=64 LMUL=4 -> VLMAX=4, AVL=9
        push_strip(9'd4, 9'd0, 1'b0); push_strip(9'd4, 9'd4, 1'b0); push_strip(9'd1, 9'd8, 1'b1);
        push_done(1'b0, 9'd3);
        run_req(8'd64, 5'd4, 9'd9, 2, 0, "t1");

        // 2: SEW=8 LMUL=8 -> VLMAX=64, AVL=500
        for (int i = 0; i < 7; i++) push_strip(9'd64, 9'(i * 64), 1'b0);
        push_strip(9'd52, 9'd448, 1'b1);
        push_done(1'b0, 9'd8);
        run_req(8'd8, 5'd8, 9'd500, 2, 0, "t2");

        // 3: illegal SEW, then illegal LMUL
        push_done(1'b1, 9'd0);
        run_req(8'd44, 5'd2, 9'd5, 1, 0, "t3a");
        push_done(1'b1, 9'd0);
        run_req(8'd64, 5'd5, 9'd5, 1, 0, "t3b");

        // 4: SEW=16 LMUL=1 -> VLMAX=4, AVL=10, 5-cycle stall per strip
        push_strip(9'd4, 9'd0, 1'b0); push_strip(9'd4, 9'd4, 1'b0); push_strip(9'd2, 9'd8, 1'b1);
        push_done(1'b0, 9'd3);
        run_req(8'd16, 5'd1, 9'd10, 2, 5, "t4");

        // 5: AVL=0
        push_done(1'b0, 9'd0);
        run_req(8'd32, 5'd2, 9'd0, 1, 0, "t5");

        // 6a: flush during the second ISSUE of SEW=8 LMUL=1 AVL=40
        push_strip(9'd8, 9'd0, 1'b0); push_strip(9'd8, 9'd8, 1'b0);
        @(posedge clk); #1;
        req_sew = 8'd8; req_lmul = 5'd1; req_avl = 9'd40; req_valid = 1'b1; strip_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g = 0;
        while (!(strip_valid && exp_strip_q.size() == 1) && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk("t6_reach_issue2", 32'(g < 20), 32'd1);
        flush = 1'b1; strip_ready = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t6_flush_state", 32'({strip_valid, busy, req_ready, done_valid}), 32'd2);
        chk("t6_flush_cleared", 32'({strip_vl, strip_base}), 32'd0);
        chk("t6_pending", 32'(exp_strip_q.size()), 32'd1);
        exp_strip_q.delete();
        repeat (3) @(posedge clk);
        #1;
        // flush in IDLE blocks a simultaneous request
        flush = 1'b1; req_valid = 1'b1; req_sew = 8'd8; req_lmul = 5'd1; req_avl = 9'd5;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("t6_flush_idle_no_accept", 32'({busy, req_ready}), 32'd1);
        repeat (2) @(posedge clk);
        // new request after flush
        push_strip(9'd3, 9'd0, 1'b1);
        push_done(1'b0, 9'd1);
        run_req(8'd8, 5'd1, 9'd3, 2, 0, "t6b");

        // 6b: asynchronous reset mid-run
        push_strip(9'd8, 9'd0, 1'b0);
        @(posedge clk); #1;
        req_sew = 8'd8; req_lmul = 5'd1; req_avl = 9'd40; req_valid = 1'b1; strip_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g = 0;
        while (!strip_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk("t6_rst_reach_issue", 32'(strip_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_req_ready", 32'(req_ready), 32'd1);
        chk("t6_rst_outputs", 32'({strip_valid, strip_vl, strip_base, strip_last, done_valid, done_err, busy}), 32'd0);
        chk("t6_rst_done_strips", 32'(done_strips), 32'd0);
        exp_strip_q.delete();
        exp_done_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_rst_idle", 32'({busy, req_ready}), 32'd1);

        chk("end_strip_q_empty", 32'(exp_strip_q.size()), 32'd0);
        chk("end_done_q_empty", 32'(exp_done_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vl_strip_sequencer.md
Name: vl_strip_sequencer

Overview:
Strip-mining controller for vector operations. Accepts one request (SEW, LMUL, total AVL) and issues a sequence of strips, each with vl = min(remaining, VLMAX) and a starting element offset, to the vector execution unit over a valid/ready handshake. Signals completion with a one-cycle done pulse. Sits between instruction decode and the vector lane datapath.

Parameters:
VLEN, 64, vector register length in bits
AVL_W, 9, width of AVL, vl, offset and remaining-count fields
CNT_W, 9, width of the strip counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; returns the block to IDLE
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_sew  in  8  element width in bits; legal values 8/16/32/64
req_lmul  in  5  register group multiplier; legal values 1/2/4/8
req_avl  in  AVL_W  total element count
strip_valid  out  1  strip descriptor valid
strip_ready  in  1  execution unit accepts strip
strip_vl  out  AVL_W  elements in this strip
strip_base  out  AVL_W  element offset of the strip's first element
strip_last  out  1  final strip of the request
done_valid  out  1  one-cycle completion pulse
done_err  out  1  qualifies done_valid; illegal SEW/LMUL
done_strips  out  CNT_W  strips issued; valid with done_valid
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, req_ready=1, all other outputs 0, internal rem/base/count/vlmax=0.
- VLMAX = (VLEN*LMUL)/SEW, computed by shifts (log2 encodings). With VLEN=64 the maximum is 64.
- States: IDLE, CALC, ISSUE, DONE.
- IDLE: req_ready=1. When req_valid&&req_ready, latch rem=avl, base=0, count=0, vlmax, and err=illegal(SEW,LMUL).
  - err=1 or avl=0 -> DONE.
  - Otherwise -> CALC.
- CALC (1 cycle): register vl=min(rem,vlmax) and last=(rem<=vlmax) -> ISSUE.
- ISSUE: strip_valid=1. strip_vl/strip_base/strip_last are registered and stay stable while strip_ready=0.
  - On strip_ready: rem-=vl, base+=vl, count+=1.
  - If last -> DONE, else -> CALC.
- DONE (1 cycle): done_valid=1, done_err=err, done_strips=count -> IDLE. req_ready=0 in this state.
- Latency: accept in cycle N; first strip_valid in cycle N+2. With strip_ready held high, each strip occupies 2 cycles. done_valid appears in the cycle after the last handshake. Error or avl=0: done_valid in cycle N+1.
- req_ready=0 in all states except IDLE. A request is never dropped or overwritten.
- flush: highest priority after reset. Next state is IDLE, strip_valid drops next cycle, no done pulse, counters cleared. flush in IDLE has no effect; a simultaneous req_valid in that cycle is not accepted.
- Arithmetic: rem and base never wrap, since base+rem=avl <= 2^AVL_W-1. count saturates at 2^CNT_W-1.
- Asynchronous reset mid-operation: immediate return to reset values; the in-flight strip is abandoned.

Decomposition:
- Shared package vl_pkg holds:
  - state enum (IDLE/CALC/ISSUE/DONE);
  - legal SEW/LMUL constants and their log2 encodings;
  - helper function sew_lmul_legal.
- One combinational sub-module, vl_strip_calc, takes (sew, lmul, rem) and returns (vlmax, vl, last, illegal). It is instantiated once; its outputs are registered in CALC.

Test Plan:
1. SEW=64, LMUL=4, AVL=9, strip_ready=1 -> strips (vl,base,last) = (4,0,0), (4,4,0), (1,8,1); done_valid with done_err=0, done_strips=3; first strip_valid 2 cycles after accept.
2. SEW=8, LMUL=8, AVL=500 -> 7 strips of vl=64 at bases 0..384, then vl=52 at base=448 with last=1; done_strips=8.
3. SEW=44, LMUL=2, AVL=5 -> no strip_valid; done_valid 1 cycle after accept with done_err=1, done_strips=0. Repeat with SEW=64, LMUL=5 -> same result.
4. SEW=16, LMUL=1, AVL=10 (VLMAX=4), strip_ready low 5 cycles on each strip -> strip fields stable while stalled; strips 4,4,2; req_ready=0 throughout.
5. AVL=0, SEW=32, LMUL=2 -> no strips; done_valid, done_err=0, done_strips=0.
6. Abort cases on SEW=8, LMUL=1, AVL=40:
   - flush during the 2nd ISSUE -> IDLE next cycle, no done pulse; a new request with AVL=3 then yields a single strip (3,0,1).
   - rst_n asserted mid-run -> all outputs at reset values immediately.
